// File: rtl/hazard_scoreboard_if.sv
// ID-stage request signals and hazard-control responses shared between the
// decode stage and hazard_scoreboard.
interface hazard_scoreboard_if #(
  parameter int AW = 5,
  parameter int SW = 2,
  parameter int CW = 32
);
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic [AW-1:0] id_dst;
  logic          id_wr;
  logic          id_load;
  logic          br_taken;
  logic          stall;
  logic          flush;
  logic          id_byp_rs;
  logic          id_byp_rt;
  logic [SW-1:0] ex_fwd_rs_sel;
  logic [SW-1:0] ex_fwd_rt_sel;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dst, id_wr,
           id_load, br_taken,
    input  stall, flush, id_byp_rs, id_byp_rt, ex_fwd_rs_sel, ex_fwd_rt_sel,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dst, id_wr,
           id_load, br_taken,
    output stall, flush, id_byp_rs, id_byp_rt, ex_fwd_rs_sel, ex_fwd_rt_sel,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks destinations of in-flight instructions past ID and produces forwarding
// selects, WB->ID bypass, load-use stall, branch flush and event counters.
module hazard_scoreboard #(
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int BR_STAGE   = 1,
  parameter int CW         = 32,
  parameter int SW         = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave sb
);

  logic [DEPTH-1:0] entValid;
  logic [DEPTH-1:0] entLoad;
  logic [AW-1:0]    entDst [DEPTH];

  logic [AW-1:0] srcReg  [2];
  logic [1:0]    srcUsed;
  logic [1:0]    haz;
  logic [1:0]    byp;
  logic [1:0]    hit;
  logic [SW-1:0] sel     [2];

  logic          stallInt;
  logic          flushInt;
  logic [SW-1:0] selRsQ;
  logic [SW-1:0] selRtQ;
  logic [CW-1:0] stallCnt;
  logic [CW-1:0] flushCnt;

  assign srcReg[0]  = sb.id_rs;
  assign srcReg[1]  = sb.id_rt;
  assign srcUsed[0] = sb.id_rs_used;
  assign srcUsed[1] = sb.id_rt_used;

  // Ascending scan with a hit flag so the youngest (lowest-index) match wins.
  always_comb begin
    haz = '0;
    byp = '0;
    hit = '0;
    sel[0] = '0;
    sel[1] = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (!hit[s] && sb.id_valid && srcUsed[s] && entValid[j] &&
            (entDst[j] == srcReg[s]) && (srcReg[s] != '0)) begin
          hit[s] = 1'b1;
          if (j == DEPTH - 1)
            byp[s] = 1'b1;
          else if (entLoad[j] && (j + 1 < LOAD_READY))
            haz[s] = 1'b1;
          else
            sel[s] = SW'(j + 1);
        end
      end
    end
  end

  assign flushInt     = sb.br_taken & ~rst;
  assign stallInt     = (|haz) & ~flushInt & ~rst;
  assign sb.flush     = flushInt;
  assign sb.stall     = stallInt;
  assign sb.id_byp_rs = byp[0] & ~rst;
  assign sb.id_byp_rt = byp[1] & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      entValid <= '0;
      selRsQ   <= '0;
      selRtQ   <= '0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      // Shift and squash in one step: stages 0..BR_STAGE hold the younger
      // instructions behind a taken branch.
      for (int unsigned j = 1; j < DEPTH; j++)
        entValid[j] <= entValid[j-1] & ~(flushInt && (j <= BR_STAGE));
      entValid[0] <= sb.id_valid & sb.id_wr & ~stallInt & ~flushInt;
      selRsQ <= (stallInt || flushInt) ? '0 : sel[0];
      selRtQ <= (stallInt || flushInt) ? '0 : sel[1];
      if (stallInt && (stallCnt != '1))
        stallCnt <= stallCnt + 1'b1;
      if (flushInt && (flushCnt != '1))
        flushCnt <= flushCnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned j = 1; j < DEPTH; j++) begin
      entDst[j]  <= entDst[j-1];
      entLoad[j] <= entLoad[j-1];
    end
    entDst[0]  <= sb.id_dst;
    entLoad[0] <= sb.id_load;
  end

  assign sb.ex_fwd_rs_sel = selRsQ;
  assign sb.ex_fwd_rt_sel = selRtQ;
  assign sb.stall_cnt     = stallCnt;
  assign sb.flush_cnt     = flushCnt;

endmodule
